alu_srcb_unit: RTL and testbench

Parametrised, registered successor to the ALU source-B operand mux in the multicycle datapath. It selects from several operand sources: the B register, two constants, the sign-extended immediate, the immediate shifted left by 2, the zero-extended immediate, an alternate input, and a multi-cycle serial left shift of the B register. The result is held in an output register. A start/busy/done handshake lets the control FSM wait out the variable-latency shift mode. The block sits between the register file/immediate path and the ALU B input.

---
 rtl/alu_srcb_unit.sv | 87 ++++++++
 tb/tb_alu_srcb_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alu_srcb_unit.sv
// rtl/alu_srcb_unit.sv - registered ALU source-B operand mux with serial shift mode
// Accepted requests complete in one cycle, except mode 111, which takes shamt+1 cycles.
module alu_srcb_unit #(
  parameter int WIDTH       = 32,
  parameter int IMM_WIDTH   = 16,
  parameter int CONST_A     = 1,
  parameter int CONST_B     = 4,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             selector,
  input  logic [WIDTH-1:0]       reg_b,
  input  logic [IMM_WIDTH-1:0]   imm,
  input  logic [WIDTH-1:0]       alt_in,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic [WIDTH-1:0]       operand_b,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                 state;
  logic [SHAMT_WIDTH-1:0] count;
  logic [WIDTH-1:0]       imm_sext;
  logic [WIDTH-1:0]       imm_zext;
  logic [WIDTH-1:0]       sel_value;
  logic                   shift_req;

  assign imm_sext  = {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  assign imm_zext  = {{(WIDTH-IMM_WIDTH){1'b0}}, imm};
  assign shift_req = (selector == 3'b111) && (shamt != '0);

  always_comb begin
    sel_value = reg_b;
    case (selector)
      3'b000:  sel_value = reg_b;
      3'b001:  sel_value = WIDTH'(CONST_A);
      3'b010:  sel_value = WIDTH'(CONST_B);
      3'b011:  sel_value = imm_sext;
      3'b100:  sel_value = alt_in;
      3'b101:  sel_value = imm_sext << 2;
      3'b110:  sel_value = imm_zext;
      default: sel_value = reg_b;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      operand_b <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            operand_b <= sel_value;
            if (shift_req) begin
              count <= shamt;
              busy  <= 1'b1;
              state <= SHIFT;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // Shifting past WIDTH simply drains to zero; latency still tracks shamt.
          operand_b <= operand_b << 1;
          count     <= count - 1'b1;
          if (count == SHAMT_WIDTH'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_srcb_unit.sv
// tb/tb_alu_srcb_unit.sv - directed and randomized checks of alu_srcb_unit against a reference model
module tb_alu_srcb_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  selector = 3'b000;
  logic [31:0] reg_b = '0;
  logic [15:0] imm = '0;
  logic [31:0] alt_in = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  alu_srcb_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .selector  (selector),
    .reg_b     (reg_b),
    .imm       (imm),
    .alt_in    (alt_in),
    .shamt     (shamt),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] sel, input logic [31:0] rb,
                                        input logic [15:0] im, input logic [31:0] al,
                                        input logic [4:0] sh);
    int simm;
    simm = int'($signed(im));
    case (sel)
      3'd0:    return rb;
      3'd1:    return 32'd1;
      3'd2:    return 32'd4;
      3'd3:    return 32'(simm);
      3'd4:    return al;
      3'd5:    return 32'(simm * 4);
      3'd6:    return {16'h0000, im};
      default: return rb << sh;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue one request and follow it to done; optionally disturb inputs while busy.
  task automatic run_op(input string tag, input logic [2:0] sel, input logic [31:0] rb,
                        input logic [15:0] im, input logic [31:0] al, input logic [4:0] sh,
                        input bit disturb);
    logic [31:0] expv;
    int exp_lat;
    int lat;
    int busy_cycles;
    expv    = model(sel, rb, im, al, sh);
    exp_lat = (sel == 3'd7 && sh != 0) ? int'(sh) + 1 : 1;
    @(negedge clk);
    selector = sel; reg_b = rb; imm = im; alt_in = al; shamt = sh; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cycles = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) busy_cycles++;
      if (disturb && busy === 1'b1) begin
        reg_b    = $urandom;
        selector = 3'($urandom);
        shamt    = 5'($urandom);
        start    = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " value"}, operand_b, expv);
    check({tag, " busy cycles"}, 32'(busy_cycles), 32'(exp_lat - 1));
    check({tag, " busy at done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, " done falls"}, 32'(done), 32'd0);
    check({tag, " hold"}, operand_b, expv);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset operand_b", operand_b, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    reset = 1'b0;

    run_op("const_b", 3'b010, 32'h0, 16'h0, 32'h0, 5'd0, 1'b0);
    run_op("sext", 3'b011, 32'h0, 16'hFFFC, 32'h0, 5'd0, 1'b0);
    run_op("sext_sl2", 3'b101, 32'h0, 16'hFFFC, 32'h0, 5'd0, 1'b0);
    run_op("zext", 3'b110, 32'h0, 16'hFFFC, 32'h0, 5'd0, 1'b0);
    run_op("shift4", 3'b111, 32'h0000_0003, 16'h0, 32'h0, 5'd4, 1'b1);
    run_op("shift0", 3'b111, 32'hDEAD_BEEF, 16'h0, 32'h0, 5'd0, 1'b0);
    run_op("shift31", 3'b111, 32'h0000_0003, 16'h0, 32'h0, 5'd31, 1'b1);

    // Back-to-back accepts with start held high.
    @(negedge clk);
    selector = 3'b000; reg_b = 32'hA5A5_0F0F; start = 1'b1;
    @(negedge clk);
    selector = 3'b001;
    check("b2b first done", 32'(done), 32'd1);
    check("b2b first value", operand_b, 32'hA5A5_0F0F);
    @(negedge clk);
    start = 1'b0;
    check("b2b second done", 32'(done), 32'd1);
    check("b2b second value", operand_b, 32'd1);
    @(negedge clk);
    check("b2b done falls", 32'(done), 32'd0);

    // Reset during the second cycle of a long shift.
    @(negedge clk);
    selector = 3'b111; reg_b = 32'h0000_00FF; shamt = 5'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort busy before", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort operand_b", operand_b, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("abort no done", 32'(done), 32'd0);
    run_op("after abort", 3'b100, 32'h0, 16'h0, 32'h1234_5678, 5'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rand%0d", i), 3'($urandom), $urandom, 16'($urandom), $urandom,
             5'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
